// File: rtl/zilla_pkg.sv
// ----------------------------------------------------------------------------
// zilla_pkg
// Shared types and constants for the Zilla forwarding / hazard logic.
//   GPR_ADDR_WIDTH_DEFAULT : default register-index width (5 -> 32 GPRs)
//   GPR_ADDR_MAX_W         : width of the rd field inside a tracker entry;
//                            narrower indices are zero-extended into it
//   FWD_SEL_NONE           : forward-select code meaning "use register file"
//   trk_entry_t            : pipeline tracker entry {rd, wr_en, is_load}
// ----------------------------------------------------------------------------
package zilla_pkg;

    localparam int GPR_ADDR_WIDTH_DEFAULT = 5;
    localparam int GPR_ADDR_MAX_W         = 8;
    localparam int FWD_SEL_NONE           = 0;

    typedef struct packed {
        logic [GPR_ADDR_MAX_W-1:0] rd;
        logic                      wr_en;
        logic                      is_load;
    } trk_entry_t;

endpackage

// File: rtl/zilla_mc_scoreboard.sv
// ----------------------------------------------------------------------------
// zilla_mc_scoreboard
// One busy bit per GPR for in-flight multi-cycle ops (mul/div/rem).
//   fwd_clk, fwd_rst             : clock, asynchronous active-low reset
//   mc_start_i / mc_rd_i         : op issued, destination (sets bit, x0 ignored)
//   mc_done_i / mc_done_rd_i     : op retired, destination (clears bit)
//   dec_valid_i, dec_wr_en_i,
//   dec_rd_i, dec_rs_i           : decode-stage instruction fields
//   sb_stall_o                   : decode touches a busy register
//   mc_busy_o                    : any bit set
// Only instantiated when ZILLA_MC_SCOREBOARD_EN is defined.
// ----------------------------------------------------------------------------
module zilla_mc_scoreboard
    import zilla_pkg::*;
#(
    parameter int GPR_ADDR_WIDTH = GPR_ADDR_WIDTH_DEFAULT,
    parameter int NUM_SRC        = 2
) (
    input  logic                              fwd_clk,
    input  logic                              fwd_rst,
    input  logic                              mc_start_i,
    input  logic [GPR_ADDR_WIDTH-1:0]         mc_rd_i,
    input  logic                              mc_done_i,
    input  logic [GPR_ADDR_WIDTH-1:0]         mc_done_rd_i,
    input  logic                              dec_valid_i,
    input  logic                              dec_wr_en_i,
    input  logic [GPR_ADDR_WIDTH-1:0]         dec_rd_i,
    input  logic [NUM_SRC*GPR_ADDR_WIDTH-1:0] dec_rs_i,
    output logic                              sb_stall_o,
    output logic                              mc_busy_o
);

    localparam int NREG = 1 << GPR_ADDR_WIDTH;

    logic [NREG-1:0] busy_q;

    // Set is applied after clear so a same-cycle start on the same register wins.
    always_ff @(posedge fwd_clk or negedge fwd_rst) begin
        if (!fwd_rst) begin
            busy_q <= '0;
        end else begin
            if (mc_done_i)
                busy_q[mc_done_rd_i] <= 1'b0;
            if (mc_start_i && (mc_rd_i != '0))
                busy_q[mc_rd_i] <= 1'b1;
        end
    end

    // Bit 0 can never be set, so x0 operands never stall here.
    always_comb begin
        sb_stall_o = 1'b0;
        if (dec_valid_i) begin
            for (int s = 0; s < NUM_SRC; s++) begin
                if (busy_q[dec_rs_i[s*GPR_ADDR_WIDTH +: GPR_ADDR_WIDTH]])
                    sb_stall_o = 1'b1;
            end
            if (dec_wr_en_i && busy_q[dec_rd_i])
                sb_stall_o = 1'b1;
        end
    end

    assign mc_busy_o = |busy_q;

endmodule

// File: rtl/zilla_fwd_hazard_unit.sv
// ----------------------------------------------------------------------------
// zilla_fwd_hazard_unit
// Tracks destinations from ID/EX through FWD_DEPTH later stages and produces
// per-source forward selects plus the decode stall for load-use hazards.
//   fwd_clk, fwd_rst        : clock, asynchronous active-low reset
//   dec_valid_i, dec_rd_i,
//   dec_wr_en_i, dec_is_load_i,
//   dec_rs_i                : decode-stage instruction (src0 in LSBs)
//   stall_i                 : freeze ID/EX and the stage chain
//   flush_i                 : kill decode and ID/EX (bubble into ID/EX)
//   mc_start_i / mc_rd_i,
//   mc_done_i / mc_done_rd_i: multi-cycle op issue / retire
//   fwd_sel_o               : per-source select, 0 = regfile, k = stage k
//   hazard_stall_o          : decode must hold this cycle
//   mc_busy_o               : any multi-cycle destination outstanding
// Optional feature: define ZILLA_MC_SCOREBOARD_EN to add the multi-cycle
// scoreboard; otherwise mc_* inputs are ignored and mc_busy_o is 0.
// ----------------------------------------------------------------------------
module zilla_fwd_hazard_unit
    import zilla_pkg::*;
#(
    parameter  int GPR_ADDR_WIDTH = GPR_ADDR_WIDTH_DEFAULT,
    parameter  int FWD_DEPTH      = 3,
    parameter  int NUM_SRC        = 2,
    localparam int SEL_W          = $clog2(FWD_DEPTH + 1)
) (
    input  logic                              fwd_clk,
    input  logic                              fwd_rst,
    input  logic                              dec_valid_i,
    input  logic [GPR_ADDR_WIDTH-1:0]         dec_rd_i,
    input  logic                              dec_wr_en_i,
    input  logic                              dec_is_load_i,
    input  logic [NUM_SRC*GPR_ADDR_WIDTH-1:0] dec_rs_i,
    input  logic                              stall_i,
    input  logic                              flush_i,
    input  logic                              mc_start_i,
    input  logic [GPR_ADDR_WIDTH-1:0]         mc_rd_i,
    input  logic                              mc_done_i,
    input  logic [GPR_ADDR_WIDTH-1:0]         mc_done_rd_i,
    output logic [NUM_SRC*SEL_W-1:0]          fwd_sel_o,
    output logic                              hazard_stall_o,
    output logic                              mc_busy_o
);

    function automatic logic [GPR_ADDR_MAX_W-1:0] widen(input logic [GPR_ADDR_WIDTH-1:0] a);
        return GPR_ADDR_MAX_W'(a);
    endfunction

    trk_entry_t                        idex_q;
    logic [NUM_SRC*GPR_ADDR_WIDTH-1:0] idex_rs_q;
    // Chain index k-1 holds forwarding stage k.
    logic [GPR_ADDR_MAX_W-1:0]         chain_rd_q [FWD_DEPTH];
    logic                              chain_wr_q [FWD_DEPTH];

    trk_entry_t dec_entry;
    logic       load_use;
    logic       sb_stall;
    logic       accept;

    assign dec_entry = '{rd: widen(dec_rd_i), wr_en: dec_wr_en_i, is_load: dec_is_load_i};

    // Forward select: scan from the farthest stage down so the nearest match wins.
    always_comb begin
        fwd_sel_o = {NUM_SRC{SEL_W'(FWD_SEL_NONE)}};
        for (int s = 0; s < NUM_SRC; s++) begin
            for (int k = FWD_DEPTH; k >= 1; k--) begin
                if (chain_wr_q[k-1] && (chain_rd_q[k-1] != '0) &&
                    (chain_rd_q[k-1] == widen(idex_rs_q[s*GPR_ADDR_WIDTH +: GPR_ADDR_WIDTH])))
                    fwd_sel_o[s*SEL_W +: SEL_W] = SEL_W'(k);
            end
        end
    end

    // Load-use uses only decode inputs and the registered ID/EX entry, keeping
    // the stall independent of the forward-select logic.
    always_comb begin
        load_use = 1'b0;
        if (dec_valid_i && idex_q.is_load && idex_q.wr_en && (idex_q.rd != '0)) begin
            for (int s = 0; s < NUM_SRC; s++) begin
                if (idex_q.rd == widen(dec_rs_i[s*GPR_ADDR_WIDTH +: GPR_ADDR_WIDTH]))
                    load_use = 1'b1;
            end
        end
    end

`ifdef ZILLA_MC_SCOREBOARD_EN
    zilla_mc_scoreboard #(
        .GPR_ADDR_WIDTH (GPR_ADDR_WIDTH),
        .NUM_SRC        (NUM_SRC)
    ) u_mc_scoreboard (
        .fwd_clk      (fwd_clk),
        .fwd_rst      (fwd_rst),
        .mc_start_i   (mc_start_i),
        .mc_rd_i      (mc_rd_i),
        .mc_done_i    (mc_done_i),
        .mc_done_rd_i (mc_done_rd_i),
        .dec_valid_i  (dec_valid_i),
        .dec_wr_en_i  (dec_wr_en_i),
        .dec_rd_i     (dec_rd_i),
        .dec_rs_i     (dec_rs_i),
        .sb_stall_o   (sb_stall),
        .mc_busy_o    (mc_busy_o)
    );
`else
    logic mc_unused;
    assign mc_unused = ^{mc_start_i, mc_rd_i, mc_done_i, mc_done_rd_i};
    assign sb_stall  = 1'b0;
    assign mc_busy_o = 1'b0;
`endif

    assign hazard_stall_o = !flush_i && (load_use || sb_stall);
    assign accept         = dec_valid_i && !hazard_stall_o && !flush_i;

    // ID/EX -> stage 1 -> ... -> stage FWD_DEPTH
    always_ff @(posedge fwd_clk or negedge fwd_rst) begin
        if (!fwd_rst) begin
            idex_q    <= '0;
            idex_rs_q <= '0;
            for (int k = 0; k < FWD_DEPTH; k++) begin
                chain_rd_q[k] <= '0;
                chain_wr_q[k] <= 1'b0;
            end
        end else begin
            if (!stall_i) begin
                chain_rd_q[0] <= idex_q.rd;
                chain_wr_q[0] <= idex_q.wr_en;
                for (int k = 1; k < FWD_DEPTH; k++) begin
                    chain_rd_q[k] <= chain_rd_q[k-1];
                    chain_wr_q[k] <= chain_wr_q[k-1];
                end
            end
            // Flush overrides the freeze for ID/EX only.
            if (flush_i || (!stall_i && !accept)) begin
                idex_q    <= '0;
                idex_rs_q <= '0;
            end else if (!stall_i) begin
                idex_q    <= dec_entry;
                idex_rs_q <= dec_rs_i;
            end
        end
    end

endmodule

// File: tb/tb_zilla_fwd_hazard_unit.sv
// ----------------------------------------------------------------------------
// tb_zilla_fwd_hazard_unit
// Directed stimulus for zilla_fwd_hazard_unit (GPR_ADDR_WIDTH=5, FWD_DEPTH=3,
// NUM_SRC=2). The driver pushes the expected outputs for a cycle into a queue;
// a monitor on the falling edge pops and compares.
// ----------------------------------------------------------------------------
module tb_zilla_fwd_hazard_unit;

`ifdef ZILLA_MC_SCOREBOARD_EN
    localparam bit SB = 1'b1;
`else
    localparam bit SB = 1'b0;
`endif

    logic       fwd_clk;
    logic       fwd_rst;
    logic       dec_valid_i;
    logic [4:0] dec_rd_i;
    logic       dec_wr_en_i;
    logic       dec_is_load_i;
    logic [9:0] dec_rs_i;
    logic       stall_i;
    logic       flush_i;
    logic       mc_start_i;
    logic [4:0] mc_rd_i;
    logic       mc_done_i;
    logic [4:0] mc_done_rd_i;
    logic [3:0] fwd_sel_o;
    logic       hazard_stall_o;
    logic       mc_busy_o;

    zilla_fwd_hazard_unit dut (
        .fwd_clk        (fwd_clk),
        .fwd_rst        (fwd_rst),
        .dec_valid_i    (dec_valid_i),
        .dec_rd_i       (dec_rd_i),
        .dec_wr_en_i    (dec_wr_en_i),
        .dec_is_load_i  (dec_is_load_i),
        .dec_rs_i       (dec_rs_i),
        .stall_i        (stall_i),
        .flush_i        (flush_i),
        .mc_start_i     (mc_start_i),
        .mc_rd_i        (mc_rd_i),
        .mc_done_i      (mc_done_i),
        .mc_done_rd_i   (mc_done_rd_i),
        .fwd_sel_o      (fwd_sel_o),
        .hazard_stall_o (hazard_stall_o),
        .mc_busy_o      (mc_busy_o)
    );

    initial fwd_clk = 1'b0;
    always #5 fwd_clk = ~fwd_clk;

    typedef struct {
        string      name;
        logic [3:0] sel;
        logic       stall;
        logic       busy;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   checks = 0;
    int   errors = 0;

    // Monitor: outputs are settled by the falling edge.
    always @(negedge fwd_clk) begin
        if (exp_q.size() > 0) begin
            mon_e = exp_q.pop_front();
            checks++;
            if (fwd_sel_o !== mon_e.sel || hazard_stall_o !== mon_e.stall || mc_busy_o !== mon_e.busy) begin
                errors++;
                $display("FAIL %s: got sel=%h stall=%b busy=%b, expected sel=%h stall=%b busy=%b",
                         mon_e.name, fwd_sel_o, hazard_stall_o, mc_busy_o,
                         mon_e.sel, mon_e.stall, mon_e.busy);
            end
        end
    end

    task automatic expect_out(input string nm, input int s1, input int s0,
                              input bit st, input bit bz);
        exp_t e;
        e.name  = nm;
        e.sel   = {2'(s1), 2'(s0)};
        e.stall = st;
        e.busy  = bz;
        exp_q.push_back(e);
    endtask

    task automatic issue(input int rd, input bit wr, input bit ld, input int rs0, input int rs1);
        dec_valid_i   = 1'b1;
        dec_rd_i      = 5'(rd);
        dec_wr_en_i   = wr;
        dec_is_load_i = ld;
        dec_rs_i      = {5'(rs1), 5'(rs0)};
    endtask

    task automatic nop();
        dec_valid_i   = 1'b0;
        dec_rd_i      = '0;
        dec_wr_en_i   = 1'b0;
        dec_is_load_i = 1'b0;
        dec_rs_i      = '0;
    endtask

    // Advance one cycle; one-shot controls drop after the edge.
    task automatic tick();
        @(posedge fwd_clk);
        #1;
        flush_i    = 1'b0;
        mc_start_i = 1'b0;
        mc_done_i  = 1'b0;
    endtask

    initial begin
        fwd_rst = 1'b0;
        nop();
        stall_i = 1'b0; flush_i = 1'b0;
        mc_start_i = 1'b0; mc_rd_i = '0; mc_done_i = 1'b0; mc_done_rd_i = '0;
        tick();
        expect_out("reset_state", 0, 0, 0, 0);
        tick();
        fwd_rst = 1'b1;

        // Back-to-back ALU: add x5 ; sub x6,x5,x7
        issue(5, 1, 0, 1, 2);  expect_out("b2b_pre", 0, 0, 0, 0); tick();
        issue(6, 1, 0, 5, 7);  expect_out("b2b_dec", 0, 0, 0, 0); tick();
        nop();                 expect_out("b2b_fwd", 0, 1, 0, 0); tick();

        // Distance 3: write x9, two independents, reader of x9
        issue(9, 1, 0, 0, 0);  tick();
        issue(12, 1, 0, 1, 2); tick();
        issue(14, 1, 0, 1, 2); tick();
        issue(0, 0, 0, 9, 1);  tick();
        nop();                 expect_out("dist3", 0, 3, 0, 0); tick();
        // Distance 4: out of forwarding range
        issue(13, 1, 0, 0, 0); tick();
        issue(16, 1, 0, 1, 2); tick();
        issue(17, 1, 0, 1, 2); tick();
        issue(18, 1, 0, 1, 2); tick();
        issue(0, 0, 0, 13, 0); tick();
        nop();                 expect_out("dist4", 0, 0, 0, 0); tick();

        // Load-use: lw x4 ; add x8,x4,x4. The bubble sits between them, so
        // when the add reaches ID/EX the load is in stage 2.
        issue(4, 1, 1, 1, 0);  tick();
        issue(8, 1, 0, 4, 4);  expect_out("lu_stall", 0, 0, 1, 0); tick();
        issue(8, 1, 0, 4, 4);  expect_out("lu_release", 0, 0, 0, 0); tick();
        nop();                 expect_out("lu_fwd", 2, 2, 0, 0); tick();
        // lw x0 ; reader of x0
        issue(0, 1, 1, 1, 1);  tick();
        issue(0, 0, 0, 0, 0);  expect_out("lw_x0_nostall", 0, 0, 0, 0); tick();
        nop();                 expect_out("lw_x0_sel", 0, 0, 0, 0); tick();

        // Nearest wins, then a 4-cycle freeze
        issue(3, 1, 0, 1, 1);  tick();
        issue(3, 1, 0, 2, 2);  tick();
        issue(0, 0, 0, 3, 3);  tick();
        nop();
        stall_i = 1'b1;
        for (int i = 0; i < 4; i++) begin
            expect_out("stall_hold", 1, 1, 0, 0);
            tick();
        end
        stall_i = 1'b0;
        expect_out("stall_after", 1, 1, 0, 0); tick();

        // Multi-cycle scoreboard
        nop(); mc_start_i = 1'b1; mc_rd_i = 5'd10;
        expect_out("mc_pre", 0, 0, 0, 0); tick();
        issue(0, 0, 0, 10, 0); expect_out("mc_stall", 0, 0, SB, SB); tick();
        issue(0, 0, 0, 10, 0); mc_done_i = 1'b1; mc_done_rd_i = 5'd10;
        expect_out("mc_stall_done", 0, 0, SB, SB); tick();
        issue(0, 0, 0, 10, 0); expect_out("mc_clear", 0, 0, 0, 0); tick();
        nop(); mc_start_i = 1'b1; mc_rd_i = 5'd11; mc_done_i = 1'b1; mc_done_rd_i = 5'd11;
        expect_out("mc_pre11", 0, 0, 0, 0); tick();
        issue(0, 0, 0, 0, 11); expect_out("mc_same_cycle", 0, 0, SB, SB); tick();
        nop(); mc_done_i = 1'b1; mc_done_rd_i = 5'd11;
        expect_out("mc_busy11", 0, 0, 0, SB); tick();
        nop(); mc_start_i = 1'b1; mc_rd_i = 5'd0;
        expect_out("mc_idle", 0, 0, 0, 0); tick();
        nop();                 expect_out("mc_x0", 0, 0, 0, 0); tick();

        // Flush with a load in ID/EX
        issue(21, 1, 0, 1, 1); tick();
        issue(20, 1, 1, 21, 0); tick();
        issue(0, 0, 0, 20, 0); flush_i = 1'b1;
        expect_out("flush_cycle", 0, 1, 0, 0); tick();
        issue(0, 0, 0, 20, 0); expect_out("flush_after", 0, 0, 0, 0); tick();
        // Flush during a freeze: ID/EX bubbles, chain holds
        issue(23, 1, 0, 1, 1); tick();
        issue(0, 0, 0, 23, 0); tick();
        nop(); stall_i = 1'b1; flush_i = 1'b1;
        expect_out("flush_stall", 0, 1, 0, 0); tick();
        stall_i = 1'b0;
        issue(0, 0, 0, 23, 0); expect_out("flush_stall_after", 0, 0, 0, 0); tick();
        nop();                 expect_out("chain_held", 0, 2, 0, 0); tick();

        // Asynchronous reset mid-sequence
        issue(24, 1, 0, 1, 1); mc_start_i = 1'b1; mc_rd_i = 5'd25; tick();
        issue(0, 0, 0, 24, 24); tick();
        nop(); stall_i = 1'b1;
        expect_out("pre_reset", 1, 1, 0, SB); tick();
        fwd_rst = 1'b0;
        expect_out("async_reset", 0, 0, 0, 0); tick();
        fwd_rst = 1'b1; stall_i = 1'b0;
        issue(0, 0, 0, 24, 24); expect_out("post_reset_dec", 0, 0, 0, 0); tick();
        nop();                 expect_out("post_reset_sel", 0, 0, 0, 0); tick();

        for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge fwd_clk);
        if (exp_q.size() > 0) begin
            $display("FAIL drain: %0d expectations unchecked, required 0", exp_q.size());
            errors += exp_q.size();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
